alu_acc: RTL
============

// Module: alu_acc
// PURPOSE
//  Accumulator/ALU stage directly downstream of the B-bus source mux. Samples B_bus
//  on an accepted start, combines it with the AC register and writes the result
//  back to AC. AC is then one of the B-bus sources.
//  Single-cycle ops: LOAD, ADD, SUB, AND, OR, INC, SHL, SHR, CLR.
//  Multi-cycle ops: MUL (shift-add) and DIV (restoring), which free the bus after the start cycle.
// PARAMETERS
//  WIDTH     16  datapath width of AC and B_bus
//  CNT_W     5   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk       in   1      single system clock, rising edge
//  reset     in   1      synchronous, active-high reset
//  B_bus     in   WIDTH  operand from the B-bus mux; sampled only on an accepted start
//  alu_op    in   4      0 NOP,1 LOAD,2 ADD,3 SUB,4 AND,5 OR,6 INC,7 SHL,8 SHR,9 CLR,10 MUL,11 DIV; 12-15 behave as NOP
//  start     in   1      request; accepted only when busy=0
//  AC        out  WIDTH  accumulator register
//  z_flag    out  1      1 when the AC value last written by a completed op is zero
//  c_flag    out  1      ADD carry / SUB borrow / SHL,SHR shifted-out bit / MUL high-half-nonzero
//  dz_flag   out  1      1 when the last DIV had a zero divisor
//  busy      out  1      multi-cycle op in progress
//  done      out  1      one-cycle pulse when a result is written to AC
// BEHAVIOUR
//  - Reset: AC=0, z_flag=1, c_flag=0, dz_flag=0, busy=0, done=0, FSM=IDLE, counter=0.
//    Reset in any state aborts the op and discards partial results.
//  - FSM states: IDLE, MUL_RUN, DIV_RUN, FINISH.
//  - Single-cycle op, start in cycle N:
//    - AC and flags update at edge N+1; done=1 during cycle N+1; busy stays 0.
//    - NOP (and codes 12-15) still pulse done; AC and flags are unchanged.
//    - Back-to-back starts every cycle are legal.
//  - ADD/SUB/INC are modulo 2**WIDTH.
//    - c_flag = carry-out for ADD/INC, borrow for SUB (AC < B_bus unsigned).
//    - SHL/SHR shift AC by 1 with zero fill; c_flag = the bit shifted out.
//    - LOAD, AND, OR, CLR: c_flag=0.
//    - Only DIV writes dz_flag; other ops leave it unchanged.
//  - MUL (unsigned), start in cycle N:
//    - B_bus latched into operand reg M; AC copied into multiplier reg Q; partial P=0.
//    - busy=1 from cycle N+1. State MUL_RUN runs exactly WIDTH iterations, one per clock:
//      if Q[0], P+=M (WIDTH+1 bits); then shift {P,Q} right by 1.
//    - Then FINISH for 1 cycle: AC <= low WIDTH bits, c_flag = |high half,
//      done=1 and busy=0 in the cycle after FINISH. Latency start->done = WIDTH+2 cycles.
//  - DIV (unsigned), AC / B_bus:
//    - Restoring division, WIDTH iterations in DIV_RUN, then FINISH, with the same timing as MUL.
//    - AC <= quotient; remainder is discarded; c_flag=0.
//    - Divisor 0: no iterations. Next cycle AC=all-ones, dz_flag=1, done=1, busy=0 (latency 1).
//  - start while busy=1 is ignored; no queuing; the op is lost, and issuing it is the controller's fault.
//  - B_bus may change freely after the start cycle; multi-cycle ops use only latched copies.
//  - z_flag is recomputed from the new AC on every done, except NOP, which holds it.
//  - done and busy are never both 1.
// STRUCTURE
//  - Shared package cpu_pkg: alu_op encodings (ALU_NOP..ALU_DIV) and the WIDTH default,
//    also used by the microcode controller that drives alu_op/start.
//  - One sub-module, seq_muldiv: owns MUL_RUN/DIV_RUN/FINISH, the counter, P/Q/M regs;
//    interface start/op/a/b -> result/flag/valid.
//  - Single-cycle ops, the flags and the AC register stay in alu_acc.
// TESTING
//  - Reset then LOAD B=0x1234 -> AC=0x1234 after 1 cycle, done pulse, z=0, busy never 1.
//  - AC=0xFFFF, ADD B=0x0001 -> AC=0x0000, c=1, z=1. Then SUB B=0x0001 -> AC=0xFFFF, c=1 (borrow).
//  - AC=0x0123, MUL B=0x0010 -> busy for WIDTH+1 cycles, done at start+18, AC=0x1230, c=0.
//    AC=0x8000, MUL B=0x0002 -> AC=0x0000, c=1, z=1.
//  - AC=0x0064, DIV B=0x0007 -> AC=0x000E at start+18. AC=0x0064, DIV B=0 -> AC=0xFFFF,
//    dz=1, done at start+1.
//  - MUL in flight, pulse start with LOAD B=0xAAAA mid-run -> ignored; MUL result appears intact.
//    Also drive random B_bus values during the run -> result unaffected.
//  - Assert reset during cycle 5 of DIV -> next cycle AC=0, busy=0, done=0, z=1.
//    A subsequent LOAD completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared CPU definitions: ALU operation encodings, the default
//               datapath width and the multiply/divide sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_WIDTH = 16;

  // Operation codes driven by the microcode controller; 12-15 act as NOP.
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_LOAD = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_INC  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_SHR  = 4'd8,
    ALU_CLR  = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIV  = 4'd11
  } alu_op_e;

  // Sequencer states; IDLE doubles as the state for single-cycle operation.
  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_MUL_RUN = 2'd1,
    MD_DIV_RUN = 2'd2,
    MD_FINISH  = 2'd3
  } md_state_e;

  // True for operations that hand off to the iterative sequencer.
  function automatic logic is_multi_cycle(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_acc_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_acc_if
// Description : B-bus operand / command inputs and accumulator status outputs
//               shared between the microcode controller and the ALU stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_acc_if #(
  parameter int WIDTH = cpu_pkg::DATA_WIDTH
);
  logic [WIDTH-1:0] B_bus;
  logic [3:0]       alu_op;
  logic             start;
  logic [WIDTH-1:0] AC;
  logic             z_flag;
  logic             c_flag;
  logic             dz_flag;
  logic             busy;
  logic             done;

  // Controller side: issues operations, observes results.
  modport master (
    output B_bus, alu_op, start,
    input  AC, z_flag, c_flag, dz_flag, busy, done
  );

  // ALU side: consumes operations, owns the accumulator.
  modport slave (
    input  B_bus, alu_op, start,
    output AC, z_flag, c_flag, dz_flag, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv
// Description : Iterative unsigned shift-add multiplier and restoring divider.
//               One iteration per clock, WIDTH iterations, then one FINISH
//               cycle during which valid is high and result/flag are stable.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int CNT_W = 5
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic             valid,
  output logic             busy
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   p;         // MUL partial product / DIV partial remainder
  logic [WIDTH-1:0] q;         // MUL multiplier / DIV dividend -> quotient
  logic [WIDTH-1:0] m;         // latched B_bus operand
  logic             div_mode;
  logic             busy_reg;
  logic             valid_reg;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             last_iter;

  // Multiply step: conditionally add M before the right shift of {P,Q}.
  assign mul_sum   = q[0] ? (p + {1'b0, m}) : p;
  // Divide step: shift {P,Q} left by one, then try subtracting the divisor.
  // The remainder is always below the divisor, so P[WIDTH] is zero here.
  assign div_shift = {p[WIDTH-1:0], q[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, m};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Sequencer FSM with iteration counter and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      p         <= '0;
      q         <= '0;
      m         <= '0;
      div_mode  <= 1'b0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            m        <= b;
            q        <= a;
            p        <= '0;
            cnt      <= '0;
            div_mode <= (op == ALU_DIV);
            busy_reg <= 1'b1;
            state    <= (op == ALU_DIV) ? MD_DIV_RUN : MD_MUL_RUN;
          end
        end
        MD_MUL_RUN: begin
          p   <= {1'b0, mul_sum[WIDTH:1]};
          q   <= {mul_sum[0], q[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            state     <= MD_FINISH;
            valid_reg <= 1'b1;
          end
        end
        MD_DIV_RUN: begin
          // Negative trial difference means restore (keep the shifted value).
          p   <= div_trial[WIDTH+1] ? div_shift : div_trial[WIDTH:0];
          q   <= {q[WIDTH-2:0], ~div_trial[WIDTH+1]};
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            state     <= MD_FINISH;
            valid_reg <= 1'b1;
          end
        end
        MD_FINISH: begin
          state     <= MD_IDLE;
          cnt       <= '0;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
        default: begin
          state     <= MD_IDLE;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Low product half and quotient both end up in Q.
  assign result = q;
  assign flag   = !div_mode && (|p[WIDTH-1:0]);
  assign valid  = valid_reg;
  assign busy   = busy_reg;

endmodule
`default_nettype wire

// File: rtl/alu_acc.sv
`default_nettype none
// ============================================================================
// Module      : alu_acc
// Description : Accumulator/ALU stage behind the B-bus mux. Single-cycle ops
//               are executed here; MUL/DIV are delegated to seq_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_acc
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int CNT_W = 5
)(
  input logic      clk,
  input logic      reset,
  alu_acc_if.slave bus
);

  logic [WIDTH-1:0] acc;
  logic             z_reg;
  logic             c_reg;
  logic             dz_reg;
  logic             done_reg;
  logic             pend_div;

  logic             md_busy;
  logic             md_valid;
  logic             md_flag;
  logic [WIDTH-1:0] md_result;

  logic             accept;
  logic             div_zero;
  logic             launch_md;
  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sub_res;
  logic [WIDTH:0]   inc_res;
  logic [WIDTH-1:0] sc_acc;
  logic             sc_c;
  logic             sc_write;

  // Starts arriving while the sequencer runs are dropped.
  assign accept    = bus.start && !md_busy;
  assign div_zero  = (bus.alu_op == ALU_DIV) && (bus.B_bus == '0);
  assign launch_md = accept && is_multi_cycle(bus.alu_op) && !div_zero;

  assign add_res = {1'b0, acc} + {1'b0, bus.B_bus};
  assign sub_res = {1'b0, acc} - {1'b0, bus.B_bus};
  assign inc_res = {1'b0, acc} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle result and carry; sc_write is low for ops that leave AC alone.
  always_comb begin
    sc_acc   = acc;
    sc_c     = c_reg;
    sc_write = 1'b1;
    case (bus.alu_op)
      ALU_LOAD: begin sc_acc = bus.B_bus;                sc_c = 1'b0;          end
      ALU_ADD:  begin sc_acc = add_res[WIDTH-1:0];       sc_c = add_res[WIDTH]; end
      ALU_SUB:  begin sc_acc = sub_res[WIDTH-1:0];       sc_c = sub_res[WIDTH]; end
      ALU_AND:  begin sc_acc = acc & bus.B_bus;          sc_c = 1'b0;          end
      ALU_OR:   begin sc_acc = acc | bus.B_bus;          sc_c = 1'b0;          end
      ALU_INC:  begin sc_acc = inc_res[WIDTH-1:0];       sc_c = inc_res[WIDTH]; end
      ALU_SHL:  begin sc_acc = {acc[WIDTH-2:0], 1'b0};   sc_c = acc[WIDTH-1];  end
      ALU_SHR:  begin sc_acc = {1'b0, acc[WIDTH-1:1]};   sc_c = acc[0];        end
      ALU_CLR:  begin sc_acc = '0;                       sc_c = 1'b0;          end
      ALU_DIV:  begin sc_acc = '1;                       sc_c = 1'b0;          end
      default:  begin sc_write = 1'b0;                                         end
    endcase
  end

  seq_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (launch_md),
    .op     (bus.alu_op),
    .a      (acc),
    .b      (bus.B_bus),
    .result (md_result),
    .flag   (md_flag),
    .valid  (md_valid),
    .busy   (md_busy)
  );

  // Accumulator, flags and done pulse; sequencer completion has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      z_reg    <= 1'b1;
      c_reg    <= 1'b0;
      dz_reg   <= 1'b0;
      done_reg <= 1'b0;
      pend_div <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (md_valid) begin
        acc      <= md_result;
        c_reg    <= md_flag;
        z_reg    <= (md_result == '0);
        done_reg <= 1'b1;
        if (pend_div) begin
          dz_reg <= 1'b0;
        end
      end else if (accept) begin
        if (launch_md) begin
          pend_div <= (bus.alu_op == ALU_DIV);
        end else begin
          done_reg <= 1'b1;
          if (sc_write) begin
            acc   <= sc_acc;
            c_reg <= sc_c;
            z_reg <= (sc_acc == '0);
          end
          if (div_zero) begin
            dz_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.AC      = acc;
  assign bus.z_flag  = z_reg;
  assign bus.c_flag  = c_reg;
  assign bus.dz_flag = dz_reg;
  assign bus.busy    = md_busy;
  assign bus.done    = done_reg;

endmodule
`default_nettype wire
